// File: rtl/sync_buf_reader.sv
// ---------------------------------------------------------------------------
// sync_buf_reader
//
// Read controller placed directly behind the synchronizer's dual-port sample
// buffer. A start command sets up a circular read of ilen samples beginning at
// istart_addr. The block drives the buffer read port, absorbs its one-cycle
// registered read latency through a 4-entry output FIFO, and presents the
// samples as a valid/ready stream with a last-sample marker.
//
// Ports
//   iclk, irst_n        clock, asynchronous active-low reset
//   istart              start request (sampled only when idle)
//   istart_addr         first buffer address of the frame
//   ilen                samples to read (0 = no-op, clamped to buffer depth)
//   iabort              synchronous abort, highest priority
//   oen_rd, or_addr     buffer read enable / address
//   iram_data           buffer read data, valid the cycle after oen_rd
//   odata, ovalid,
//   iready, olast       output sample stream
//   obusy               high while a frame is active
//   odone               one-cycle pulse after the final sample handshake
// ---------------------------------------------------------------------------
module sync_buf_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              istart,
    input  logic [ADDR_W-1:0] istart_addr,
    input  logic [LEN_W-1:0]  ilen,
    input  logic              iabort,
    output logic              oen_rd,
    output logic [ADDR_W-1:0] or_addr,
    input  logic [DATA_W-1:0] iram_data,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    input  logic              iready,
    output logic              olast,
    output logic              obusy,
    output logic              odone
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(1) << ADDR_W;
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    iss_cnt_q;     // reads still to issue
    logic [LEN_W-1:0]    out_cnt_q;     // samples still to hand off downstream
    logic                pend_q;        // a read was issued last cycle
    logic [2:0]          fifo_cnt_q;
    logic [2:0]          fifo_cnt_d;
    logic [1:0]          wr_ptr_q;
    logic [1:0]          rd_ptr_q;
    logic [DATA_W-1:0]   fifo_mem_q [4];
    logic                done_q;

    logic [LEN_W-1:0]    len_clamped_d;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_pop;

    assign len_clamped_d = (ilen > DEPTH_L) ? DEPTH_L : ilen;

    // Entries already buffered plus the read still in flight must leave room
    // for the read issued this cycle and the one after it, so the 4-entry
    // FIFO cannot overflow even when downstream stalls.
    assign credit_ok = (fifo_cnt_q + {2'b00, pend_q}) <= 3'd2;
    assign issue     = (state_q == ST_RUN) && credit_ok;

    // Read data for a read issued last cycle is on iram_data right now.
    assign push      = pend_q;
    assign pop       = ovalid && iready;
    assign last_pop  = pop && (out_cnt_q == ONE_L);

    assign oen_rd    = issue;
    assign or_addr   = addr_q;
    assign ovalid    = (fifo_cnt_q != 3'd0);
    assign odata     = ovalid ? fifo_mem_q[rd_ptr_q] : '0;
    // The head entry is the frame's final sample exactly when one sample is
    // still owed downstream.
    assign olast     = ovalid && (out_cnt_q == ONE_L);
    assign obusy     = (state_q != ST_IDLE);
    assign odone     = done_q;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control FSM, counters and FIFO pointers.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            iss_cnt_q  <= '0;
            out_cnt_q  <= '0;
            pend_q     <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
        end else if (iabort) begin
            // Clearing pend_q drops the read issued this cycle, so its data
            // never reaches the FIFO.
            state_q    <= ST_IDLE;
            iss_cnt_q  <= '0;
            out_cnt_q  <= '0;
            pend_q     <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            pend_q     <= issue;
            fifo_cnt_q <= fifo_cnt_d;
            done_q     <= last_pop;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 2'd1;
                out_cnt_q <= out_cnt_q - ONE_L;
            end

            case (state_q)
                ST_IDLE: begin
                    if (istart && (ilen != '0)) begin
                        state_q   <= ST_RUN;
                        addr_q    <= istart_addr;
                        iss_cnt_q <= len_clamped_d;
                        out_cnt_q <= len_clamped_d;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_W'(1);
                        iss_cnt_q <= iss_cnt_q - ONE_L;
                        if (iss_cnt_q == ONE_L) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage; one register per entry, written when the write pointer
    // selects it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
            always_ff @(posedge iclk or negedge irst_n) begin
                if (!irst_n) begin
                    fifo_mem_q[gi] <= '0;
                end else if (!iabort && push && (wr_ptr_q == 2'(gi))) begin
                    fifo_mem_q[gi] <= iram_data;
                end
            end
        end
    endgenerate

endmodule
